instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DEPTH, default 16, number of instruction-memory words.
REQ-002 Parameter ADDR_W, default 4, width of pc and prog_addr; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 prog_we  input  1  write enable for the instruction memory.
REQ-006 prog_addr  input  ADDR_W  write address.
REQ-007 prog_data  input  16  write word: [15:13] opcode, [12:10] rd, [9:7] rs, [6:4] rt, [6:0] imm.
REQ-008 start  input  1  begin execution from address 0.
REQ-009 stall  input  1  downstream hold request.
REQ-010 inst  output  3  issued opcode: ADD=0, ADDI=1, SW=2, LW=3, SLL=4, HALT=7; 5 and 6 are reserved.
REQ-011 rd, rs, rt  output  3 each  issued register fields.
REQ-012 imm  output  7  issued immediate.
REQ-013 inst_valid  output  1  the output fields hold a real instruction; downstream SHALL gate all control with it.
REQ-014 pc  output  ADDR_W  address of the next word to fetch.
REQ-015 busy  output  1  high when state != IDLE.
REQ-016 done  output  1  one-cycle pulse at end of program.

Function
REQ-017 Storage SHALL be DEPTH x 16 bit; writes are synchronous; reads feed registered outputs.
REQ-018 States SHALL be IDLE, RUN and FINISH.
REQ-019 IDLE: prog_we=1 SHALL write prog_data to mem[prog_addr]; start=1 SHALL set pc<=0 and state<=RUN at the same edge.
REQ-020 A write and start in the same IDLE cycle SHALL both take effect, and the written word SHALL be visible to the first fetch.
REQ-021 prog_we SHALL be ignored in RUN and FINISH, and start SHALL be ignored outside IDLE.
REQ-022 Latency: start sampled at edge N SHALL give inst_valid=1 with mem[0] after edge N+1.
REQ-023 RUN with stall=1: all outputs, pc and state SHALL hold; stall has the highest priority.
REQ-024 RUN load-use hazard condition: the current output is a valid LW, and its rd equals mem[pc].rs, or equals mem[pc].rt when mem[pc] is ADD, SLL or SW.
REQ-025 On a load-use hazard (stall=0) the block SHALL issue one bubble (inst_valid<=0, other fields hold) and SHALL hold pc.
REQ-026 RUN normal issue: outputs SHALL take fields of mem[pc], inst_valid<=1 and pc<=pc+1, wrapping mod DEPTH.
REQ-027 Issuing from pc=DEPTH-1 SHALL move the state to FINISH, with pc wrapping to 0.
REQ-028 A fetched HALT word SHALL NOT be issued; it SHALL set inst_valid<=0, hold pc and move the state to FINISH.
REQ-029 FINISH with stall=1: hold.
REQ-030 FINISH with stall=0: inst_valid<=0, done<=1 for one cycle, state<=IDLE.
REQ-031 Reserved opcodes 5 and 6 SHALL be issued unchanged with inst_valid=1.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, pc=0, inst=0, rd=rs=rt=0, imm=0, inst_valid=0, busy=0 and done=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 rst asserted mid-RUN SHALL abort the program; a new start is required to run again.

Verification
REQ-035 Load mem[0..2] = ADDI r1,5 / ADD r2,r1,r1 / HALT, then pulse start -> ADDI valid at cycle 2, ADD at cycle 3, inst_valid=0 at cycle 4, done=1 at cycle 5, busy=0 after.
REQ-036 Program LW r3 / ADD r4,r3,r0 / HALT -> sequence LW, bubble (inst_valid=0, pc=1), ADD, then done.
REQ-037 Program LW r3 / ADD r4,r1,r2 / HALT (no dependence) -> no bubble; ADD issued the cycle after LW.
REQ-038 stall=1 for 3 cycles mid-RUN -> inst, inst_valid and pc unchanged for 3 cycles, then the sequence resumes with nothing lost or duplicated.
REQ-039 16 ADD words with no HALT -> 16 consecutive valid issues, pc wraps to 0, done one cycle after the last issue.
REQ-040 rst pulsed during RUN, plus prog_we and start during RUN -> all outputs return to reset values immediately, memory is unchanged, and RUN-time writes and start are ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch/issue stage: a small program memory loaded while idle,
// then issued one word per cycle with stall, load-use bubble and HALT handling.
module instruction_fetch #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              start,
  input  logic              stall,
  output logic [2:0]        inst,
  output logic [2:0]        rd,
  output logic [2:0]        rs,
  output logic [2:0]        rt,
  output logic [6:0]        imm,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd7;

  logic [1:0]  state;
  logic [15:0] mem [DEPTH];
  logic [15:0] word;
  logic [2:0]  wordOp;
  logic [2:0]  wordRs;
  logic [2:0]  wordRt;
  logic        usesRt;
  logic        hazard;
  logic        lastAddr;

  assign word     = mem[pc];
  assign wordOp   = word[15:13];
  assign wordRs   = word[9:7];
  assign wordRt   = word[6:4];
  assign usesRt   = (wordOp == OP_ADD) || (wordOp == OP_SLL) || (wordOp == OP_SW);
  // A load still sitting on the outputs cannot forward to a consumer fetched right behind it.
  assign hazard   = inst_valid && (inst == OP_LW) &&
                    ((rd == wordRs) || (usesRt && (rd == wordRt)));
  assign lastAddr = (pc == ADDR_W'(DEPTH - 1));
  assign busy     = (state != IDLE);

  // Program memory is deliberately not reset so a loaded program survives an abort.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      inst       <= '0;
      rd         <= '0;
      rs         <= '0;
      rt         <= '0;
      imm        <= '0;
      inst_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pc    <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (stall) begin
            state <= RUN;
          end else if (hazard) begin
            inst_valid <= 1'b0;
          end else if (wordOp == OP_HALT) begin
            inst_valid <= 1'b0;
            state      <= FINISH;
          end else begin
            inst       <= wordOp;
            rd         <= word[12:10];
            rs         <= wordRs;
            rt         <= wordRt;
            imm        <= word[6:0];
            inst_valid <= 1'b1;
            pc         <= pc + ADDR_W'(1);
            if (lastAddr) begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          if (!stall) begin
            inst_valid <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed literal scenarios plus randomized
// programs compared every cycle against a word-level behavioural model.
module tb_instruction_fetch;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic              start;
  logic              stall;
  logic [2:0]        inst;
  logic [2:0]        rd;
  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [6:0]        imm;
  logic              inst_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stall(stall),
    .inst(inst), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .inst_valid(inst_valid), .pc(pc), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the last issued word, whether a program is running or winding down, and the fetch index.
  logic [15:0] mMem [DEPTH];
  logic [15:0] mOut = '0;
  logic [15:0] mNext;
  bit          mRunning = 0;
  bit          mEnding = 0;
  bit          mValid = 0;
  bit          mDone = 0;
  int          mPc = 0;

  function automatic bit loadUse(input logic [15:0] w);
    bit readsRt;
    readsRt = (w[15:13] == 3'd0) || (w[15:13] == 3'd2) || (w[15:13] == 3'd4);
    return mValid && (mOut[15:13] == 3'd3) &&
           ((mOut[12:10] == w[9:7]) || (readsRt && (mOut[12:10] == w[6:4])));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mRunning = 0; mEnding = 0; mOut = '0; mValid = 0; mDone = 0; mPc = 0;
    end else if (!mRunning && !mEnding) begin
      mDone = 0;
      if (prog_we) mMem[prog_addr] = prog_data;
      if (start) begin
        mRunning = 1;
        mPc = 0;
      end
    end else if (!stall) begin
      if (mEnding) begin
        mValid = 0; mDone = 1; mEnding = 0;
      end else begin
        mNext = mMem[mPc];
        if (loadUse(mNext)) begin
          mValid = 0;
        end else if (mNext[15:13] == 3'd7) begin
          mValid = 0; mRunning = 0; mEnding = 1;
        end else begin
          mOut = mNext;
          mValid = 1;
          if (mPc == DEPTH - 1) begin
            mRunning = 0; mEnding = 1;
          end
          mPc = (mPc + 1) % DEPTH;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("inst", int'(inst), int'(mOut[15:13]));
    checkOutput("rd", int'(rd), int'(mOut[12:10]));
    checkOutput("rs", int'(rs), int'(mOut[9:7]));
    checkOutput("rt", int'(rt), int'(mOut[6:4]));
    checkOutput("imm", int'(imm), int'(mOut[6:0]));
    checkOutput("inst_valid", int'(inst_valid), int'(mValid));
    checkOutput("pc", int'(pc), mPc);
    checkOutput("busy", int'(busy), int'(mRunning || mEnding));
    checkOutput("done", int'(done), int'(mDone));
  end

  function automatic logic [15:0] mk(input int op, input int d, input int s, input int t, input int lo);
    return {3'(op), 3'(d), 3'(s), 3'(t), 4'(lo)};
  endfunction

  function automatic logic [15:0] randWord(input bit allowHalt);
    int r;
    int op;
    r  = $urandom_range(0, 19);
    op = (allowHalt && r == 0) ? 7 : (r % 7);
    return mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
  endfunction

  task automatic applyStimulus(input bit we, input logic [ADDR_W-1:0] addr, input logic [15:0] data,
                               input bit st, input bit stl);
    prog_we = we; prog_addr = addr; prog_data = data; start = st; stall = stl;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic fillRandom(input bit allowHalt);
    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, ADDR_W'(a), randWord(allowHalt), 1'b0, 1'b0);
  endtask

  task automatic runProgram(input bit noisy);
    bit seen;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    seen = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      applyStimulus(noisy && ($urandom_range(0, 9) == 0), ADDR_W'($urandom), 16'($urandom),
                    noisy && ($urandom_range(0, 19) == 0), $urandom_range(0, 3) == 0);
      if (mDone) seen = 1;
    end
    prog_we = 1'b0; start = 1'b0; stall = 1'b0;
    checkOutput("programEnd", int'(seen), 1);
    idleCycle();
  endtask

  initial begin
    int issues;
    bit ended;
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0; stall = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetPc", int'(pc), 0);
    checkOutput("resetValid", int'(inst_valid), 0);

    // ADDI r1,5 / ADD r2,r1,r1 / HALT
    applyStimulus(1'b1, 4'd0, mk(1, 1, 0, 0, 5), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd1, mk(0, 2, 1, 1, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd2, mk(7, 0, 0, 0, 0), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("addiStartBusy", int'(busy), 1);
    checkOutput("addiStartValid", int'(inst_valid), 0);
    idleCycle();
    checkOutput("addiInst", int'(inst), 1);
    checkOutput("addiImm", int'(imm), 5);
    checkOutput("addiValid", int'(inst_valid), 1);
    idleCycle();
    checkOutput("addInst", int'(inst), 0);
    checkOutput("addRd", int'(rd), 2);
    idleCycle();
    checkOutput("haltValid", int'(inst_valid), 0);
    checkOutput("haltDone", int'(done), 0);
    idleCycle();
    checkOutput("endDone", int'(done), 1);
    checkOutput("endBusy", int'(busy), 0);
    idleCycle();
    checkOutput("donePulse", int'(done), 0);

    // LW r3 / ADD r4,r3,r0 / HALT, word 0 written together with start
    applyStimulus(1'b1, 4'd1, mk(0, 4, 3, 0, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd2, mk(7, 0, 0, 0, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd0, mk(3, 3, 0, 0, 0), 1'b1, 1'b0);
    idleCycle();
    checkOutput("lwInst", int'(inst), 3);
    checkOutput("lwValid", int'(inst_valid), 1);
    idleCycle();
    checkOutput("bubbleValid", int'(inst_valid), 0);
    checkOutput("bubblePc", int'(pc), 1);
    idleCycle();
    checkOutput("afterBubbleRd", int'(rd), 4);
    checkOutput("afterBubbleValid", int'(inst_valid), 1);
    idleCycle();
    idleCycle();
    checkOutput("hazardDone", int'(done), 1);

    // LW r3 / ADD r4,r1,r2 / HALT: independent, no bubble
    applyStimulus(1'b1, 4'd1, mk(0, 4, 1, 2, 0), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("noBubbleValid", int'(inst_valid), 1);
    checkOutput("noBubbleRd", int'(rd), 4);
    checkOutput("noBubblePc", int'(pc), 2);
    idleCycle();
    idleCycle();

    // 16 ADDs, no HALT: wraps and ends
    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, ADDR_W'(a), mk(0, 1, 2, 3, a), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    issues = 0;
    ended = 0;
    for (int n = 0; n < 40 && !ended; n++) begin
      idleCycle();
      if (inst_valid) issues++;
      if (done) ended = 1;
    end
    checkOutput("wrapIssues", issues, 16);
    checkOutput("wrapEnded", int'(ended), 1);
    checkOutput("wrapPc", int'(pc), 0);
    idleCycle();

    // Abort mid-run after ignored run-time write and start
    fillRandom(1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    idleCycle();
    idleCycle();
    applyStimulus(1'b1, 4'd5, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd6, 16'hE000, 1'b0, 1'b0);
    prog_we = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortValid", int'(inst_valid), 0);
    checkOutput("abortPc", int'(pc), 0);
    checkOutput("abortInst", int'(inst), 0);
    checkOutput("abortImm", int'(imm), 0);
    @(negedge clk);
    rst = 1'b0;
    idleCycle();
    checkOutput("abortStaysIdle", int'(busy), 0);
    runProgram(1'b0);

    for (int p = 0; p < 30; p++) begin
      fillRandom(1'b1);
      runProgram(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
